// File: rtl/punc_control_pkg.sv
// Shared encodings for the PUnC control FSM: opcodes, state codes and the
// datapath mux select values.
package punc_control_pkg;

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_EXEC2 = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [3:0] OP_BR   = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_LD   = 4'b0010;
    localparam logic [3:0] OP_ST   = 4'b0011;
    localparam logic [3:0] OP_JSR  = 4'b0100;
    localparam logic [3:0] OP_AND  = 4'b0101;
    localparam logic [3:0] OP_LDR  = 4'b0110;
    localparam logic [3:0] OP_STR  = 4'b0111;
    localparam logic [3:0] OP_RTI  = 4'b1000;
    localparam logic [3:0] OP_NOT  = 4'b1001;
    localparam logic [3:0] OP_LDI  = 4'b1010;
    localparam logic [3:0] OP_STI  = 4'b1011;
    localparam logic [3:0] OP_JMP  = 4'b1100;
    localparam logic [3:0] OP_RES  = 4'b1101;
    localparam logic [3:0] OP_LEA  = 4'b1110;
    localparam logic [3:0] OP_TRAP = 4'b1111;

    localparam int BR_N = 11;
    localparam int BR_Z = 10;
    localparam int BR_P = 9;

    localparam logic [1:0] PC_SEL_SEXT9  = 2'd0;
    localparam logic [1:0] PC_SEL_SEXT11 = 2'd1;
    localparam logic [1:0] PC_SEL_RQ     = 2'd2;

    localparam logic [1:0] RADDR_PC      = 2'd0;
    localparam logic [1:0] RADDR_SEXT9   = 2'd1;
    localparam logic [1:0] RADDR_TEMP    = 2'd2;
    localparam logic [1:0] RADDR_RQ_SEXT = 2'd3;

    localparam logic [1:0] WADDR_SEXT9   = 2'd0;
    localparam logic [1:0] WADDR_TEMP    = 2'd1;
    localparam logic [1:0] WADDR_RQ_SEXT = 2'd2;

    localparam logic [1:0] WDATA_ALU     = 2'd0;
    localparam logic [1:0] WDATA_DMEM    = 2'd1;
    localparam logic [1:0] WDATA_SEXT9   = 2'd2;
    localparam logic [1:0] WDATA_PC      = 2'd3;

    localparam logic RF_WADDR_IR = 1'b0;
    localparam logic RF_WADDR_R7 = 1'b1;

    localparam logic RP_ADDR_11_9 = 1'b0;
    localparam logic RP_ADDR_2_0  = 1'b1;

    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_AND  = 2'd1;
    localparam logic [1:0] ALU_NOT  = 2'd2;
    localparam logic [1:0] ALU_PASS = 2'd3;

    function automatic logic [3:0] opcode(input logic [15:0] instr);
        return instr[15:12];
    endfunction

endpackage

// File: rtl/punc_control.sv
// PUnC LC3 control FSM: fetch / execute / second-execute sequencing with all
// datapath control outputs decoded combinationally from state, ir and nzp_match.
module punc_control
    import punc_control_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ir,
    input  logic        nzp_match,
    output logic        pc_ld,
    output logic        pc_clr,
    output logic        pc_inc,
    output logic [1:0]  pc_sel,
    output logic        ir_ld,
    output logic        ir_clr,
    output logic        dmem_rd,
    output logic        dmem_wr,
    output logic [1:0]  dmem_r_addr_sel,
    output logic [1:0]  dmem_w_addr_sel,
    output logic [1:0]  rf_w_data_sel,
    output logic        rf_w_addr_sel,
    output logic        rf_w_wr,
    output logic        rf_rp_addr_sel,
    output logic        rf_rp_rd,
    output logic        rf_rq_rd,
    output logic        temp_ld,
    output logic        nzp_ld,
    output logic        nzp_clr,
    output logic [1:0]  alu_sel,
    output logic        alu_in_a_sel,
    output logic        halted
);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] op;

    // Only the opcode, ir[11] (JSR vs JSRR) and ir[5] (immediate select) steer control.
    logic unused_ir_bits;
    assign unused_ir_bits = ^{ir[10:6], ir[4:0]};

    assign op = opcode(ir);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        pc_ld           = 1'b0;
        pc_clr          = 1'b0;
        pc_inc          = 1'b0;
        pc_sel          = PC_SEL_SEXT9;
        ir_ld           = 1'b0;
        ir_clr          = 1'b0;
        dmem_rd         = 1'b0;
        dmem_wr         = 1'b0;
        dmem_r_addr_sel = RADDR_PC;
        dmem_w_addr_sel = WADDR_SEXT9;
        rf_w_data_sel   = WDATA_ALU;
        rf_w_addr_sel   = RF_WADDR_IR;
        rf_w_wr         = 1'b0;
        rf_rp_addr_sel  = RP_ADDR_11_9;
        rf_rp_rd        = 1'b0;
        rf_rq_rd        = 1'b0;
        temp_ld         = 1'b0;
        nzp_ld          = 1'b0;
        nzp_clr         = 1'b0;
        alu_sel         = ALU_ADD;
        alu_in_a_sel    = 1'b0;
        halted          = 1'b0;

        case (state_q)
            S_INIT: begin
                pc_clr  = 1'b1;
                ir_clr  = 1'b1;
                nzp_clr = 1'b1;
                state_d = S_FETCH;
            end

            S_FETCH: begin
                dmem_rd         = 1'b1;
                dmem_r_addr_sel = RADDR_PC;
                ir_ld           = 1'b1;
                pc_inc          = 1'b1;
                state_d         = S_EXEC;
            end

            S_EXEC: begin
                state_d = S_FETCH;
                case (op)
                    OP_ADD, OP_AND, OP_NOT: begin
                        rf_w_wr        = 1'b1;
                        rf_w_addr_sel  = RF_WADDR_IR;
                        rf_w_data_sel  = WDATA_ALU;
                        rf_rq_rd       = 1'b1;
                        rf_rp_addr_sel = RP_ADDR_2_0;
                        rf_rp_rd       = (op != OP_NOT);
                        alu_in_a_sel   = ir[5];
                        nzp_ld         = 1'b1;
                        alu_sel        = (op == OP_ADD) ? ALU_ADD :
                                         (op == OP_AND) ? ALU_AND : ALU_NOT;
                    end
                    OP_BR: begin
                        pc_ld  = nzp_match;
                        pc_sel = PC_SEL_SEXT9;
                    end
                    OP_JMP: begin
                        rf_rq_rd = 1'b1;
                        pc_ld    = 1'b1;
                        pc_sel   = PC_SEL_RQ;
                    end
                    OP_JSR: begin
                        // R7 <= PC while Rq is read the same cycle, so JSRR R7 sees the old R7.
                        rf_w_wr       = 1'b1;
                        rf_w_addr_sel = RF_WADDR_R7;
                        rf_w_data_sel = WDATA_PC;
                        pc_ld         = 1'b1;
                        pc_sel        = ir[11] ? PC_SEL_SEXT11 : PC_SEL_RQ;
                        rf_rq_rd      = 1'b1;
                    end
                    OP_LD, OP_LDR: begin
                        dmem_rd         = 1'b1;
                        dmem_r_addr_sel = (op == OP_LD) ? RADDR_SEXT9 : RADDR_RQ_SEXT;
                        rf_rq_rd        = (op == OP_LDR);
                        rf_w_wr         = 1'b1;
                        rf_w_data_sel   = WDATA_DMEM;
                        nzp_ld          = 1'b1;
                    end
                    OP_LEA: begin
                        rf_w_wr       = 1'b1;
                        rf_w_data_sel = WDATA_SEXT9;
                        nzp_ld        = 1'b1;
                    end
                    OP_ST, OP_STR: begin
                        dmem_wr         = 1'b1;
                        rf_rp_rd        = 1'b1;
                        rf_rp_addr_sel  = RP_ADDR_11_9;
                        dmem_w_addr_sel = (op == OP_ST) ? WADDR_SEXT9 : WADDR_RQ_SEXT;
                        rf_rq_rd        = (op == OP_STR);
                    end
                    OP_LDI, OP_STI: begin
                        dmem_rd         = 1'b1;
                        dmem_r_addr_sel = RADDR_SEXT9;
                        temp_ld         = 1'b1;
                        state_d         = S_EXEC2;
                    end
                    OP_TRAP: begin
                        state_d = S_HALT;
                    end
                    default: begin
                    end
                endcase
            end

            S_EXEC2: begin
                state_d = S_FETCH;
                if (op == OP_LDI) begin
                    dmem_rd         = 1'b1;
                    dmem_r_addr_sel = RADDR_TEMP;
                    rf_w_wr         = 1'b1;
                    rf_w_data_sel   = WDATA_DMEM;
                    nzp_ld          = 1'b1;
                end else begin
                    dmem_wr         = 1'b1;
                    dmem_w_addr_sel = WADDR_TEMP;
                    rf_rp_rd        = 1'b1;
                    rf_rp_addr_sel  = RP_ADDR_11_9;
                end
            end

            S_HALT: begin
                halted = 1'b1;
            end

            default: begin
                state_d = S_INIT;
            end
        endcase
    end

endmodule

// File: tb/tb_punc_control.sv
// Bench for punc_control: table of single instructions walked through
// FETCH/EXEC(/EXEC2), plus hand sequences for reset-in-EXEC2 and HALT.
module tb_punc_control;

    typedef struct packed {
        logic       pc_ld;
        logic       pc_clr;
        logic       pc_inc;
        logic [1:0] pc_sel;
        logic       ir_ld;
        logic       ir_clr;
        logic       dmem_rd;
        logic       dmem_wr;
        logic [1:0] dmem_r_addr_sel;
        logic [1:0] dmem_w_addr_sel;
        logic [1:0] rf_w_data_sel;
        logic       rf_w_addr_sel;
        logic       rf_w_wr;
        logic       rf_rp_addr_sel;
        logic       rf_rp_rd;
        logic       rf_rq_rd;
        logic       temp_ld;
        logic       nzp_ld;
        logic       nzp_clr;
        logic [1:0] alu_sel;
        logic       alu_in_a_sel;
        logic       halted;
    } ctl_t;

    localparam int W = $bits(ctl_t);

    typedef struct {
        string      name;
        logic [15:0] ir;
        logic       nzp;
        ctl_t       exp_exec;
        logic       has2;
        ctl_t       exp_exec2;
    } vec_t;

    logic        clk;
    logic        rst;
    logic [15:0] ir;
    logic        nzp_match;
    ctl_t        act;

    logic [W-1:0] exp_q[$];
    int total_cnt;
    int pass_cnt;

    punc_control dut (
        .clk             (clk),
        .rst             (rst),
        .ir              (ir),
        .nzp_match       (nzp_match),
        .pc_ld           (act.pc_ld),
        .pc_clr          (act.pc_clr),
        .pc_inc          (act.pc_inc),
        .pc_sel          (act.pc_sel),
        .ir_ld           (act.ir_ld),
        .ir_clr          (act.ir_clr),
        .dmem_rd         (act.dmem_rd),
        .dmem_wr         (act.dmem_wr),
        .dmem_r_addr_sel (act.dmem_r_addr_sel),
        .dmem_w_addr_sel (act.dmem_w_addr_sel),
        .rf_w_data_sel   (act.rf_w_data_sel),
        .rf_w_addr_sel   (act.rf_w_addr_sel),
        .rf_w_wr         (act.rf_w_wr),
        .rf_rp_addr_sel  (act.rf_rp_addr_sel),
        .rf_rp_rd        (act.rf_rp_rd),
        .rf_rq_rd        (act.rf_rq_rd),
        .temp_ld         (act.temp_ld),
        .nzp_ld          (act.nzp_ld),
        .nzp_clr         (act.nzp_clr),
        .alu_sel         (act.alu_sel),
        .alu_in_a_sel    (act.alu_in_a_sel),
        .halted          (act.halted)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected bundles for the fixed states
    function automatic ctl_t exp_init();
        ctl_t e = '0;
        e.pc_clr = 1'b1; e.ir_clr = 1'b1; e.nzp_clr = 1'b1;
        return e;
    endfunction

    function automatic ctl_t exp_fetch();
        ctl_t e = '0;
        e.dmem_rd = 1'b1; e.ir_ld = 1'b1; e.pc_inc = 1'b1; e.dmem_r_addr_sel = 2'd0;
        return e;
    endfunction

    function automatic ctl_t exp_halt();
        ctl_t e = '0;
        e.halted = 1'b1;
        return e;
    endfunction

    task automatic push_exp(input ctl_t e);
        exp_q.push_back(W'(e));
    endtask

    // Compare one cycle of DUT outputs at the falling edge, then advance past
    // the next rising edge so the caller can drive the following cycle.
    task automatic check_cycle(input string name);
        logic [W-1:0] e;
        @(negedge clk);
        if (exp_q.size() == 0) begin
            total_cnt++;
            $display("FAIL %s: expected queue empty", name);
        end else begin
            e = exp_q.pop_front();
            total_cnt++;
            if (W'(act) === e) pass_cnt++;
            else $display("FAIL %s: got %h, expected %h", name, W'(act), e);
        end
        total_cnt++;
        if (!(act.dmem_wr && act.rf_w_wr) && !(act.pc_ld && act.pc_inc)) pass_cnt++;
        else $display("FAIL %s_excl: dmem_wr=%b rf_w_wr=%b pc_ld=%b pc_inc=%b, exclusive pairs required",
                      name, act.dmem_wr, act.rf_w_wr, act.pc_ld, act.pc_inc);
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[$];

    task automatic add_vec(input string name, input logic [15:0] i, input logic n,
                           input ctl_t e1, input logic h2, input ctl_t e2);
        vec_t v;
        v.name = name; v.ir = i; v.nzp = n; v.exp_exec = e1; v.has2 = h2; v.exp_exec2 = e2;
        vecs.push_back(v);
    endtask

    initial begin
        ctl_t e;
        ctl_t e2;
        ctl_t z;
        total_cnt = 0;
        pass_cnt  = 0;
        z = '0;

        // ADD R1,R1,#2
        e = '0; e.rf_w_wr = 1; e.rf_rq_rd = 1; e.rf_rp_rd = 1; e.rf_rp_addr_sel = 1;
        e.alu_sel = 2'd0; e.alu_in_a_sel = 1; e.nzp_ld = 1;
        add_vec("add_imm", 16'h1262, 1'b0, e, 1'b0, z);
        // ADD R0,R1,R2
        e.alu_in_a_sel = 0;
        add_vec("add_reg", 16'h1042, 1'b1, e, 1'b0, z);
        // AND R1,R1,#0
        e.alu_sel = 2'd1; e.alu_in_a_sel = 1;
        add_vec("and_imm", 16'h5260, 1'b0, e, 1'b0, z);
        // NOT R1,R1
        e = '0; e.rf_w_wr = 1; e.rf_rq_rd = 1; e.rf_rp_addr_sel = 1;
        e.alu_sel = 2'd2; e.alu_in_a_sel = 1; e.nzp_ld = 1;
        add_vec("not", 16'h927F, 1'b0, e, 1'b0, z);
        // BRz not taken / taken
        add_vec("brz_nt", 16'h0402, 1'b0, z, 1'b0, z);
        e = '0; e.pc_ld = 1; e.pc_sel = 2'd0;
        add_vec("brz_t", 16'h0402, 1'b1, e, 1'b0, z);
        add_vec("br_always", 16'h01FE, 1'b1, e, 1'b0, z);
        // JMP R7
        e = '0; e.rf_rq_rd = 1; e.pc_ld = 1; e.pc_sel = 2'd2;
        add_vec("jmp", 16'hC1C0, 1'b0, e, 1'b0, z);
        // JSR -1 and JSRR R7
        e = '0; e.rf_w_wr = 1; e.rf_w_addr_sel = 1; e.rf_w_data_sel = 2'd3;
        e.pc_ld = 1; e.pc_sel = 2'd1; e.rf_rq_rd = 1;
        add_vec("jsr", 16'h4FFF, 1'b0, e, 1'b0, z);
        e.pc_sel = 2'd2;
        add_vec("jsrr", 16'h41C0, 1'b0, e, 1'b0, z);
        // LD / LDR / LEA
        e = '0; e.dmem_rd = 1; e.dmem_r_addr_sel = 2'd1; e.rf_w_wr = 1;
        e.rf_w_data_sel = 2'd1; e.nzp_ld = 1;
        add_vec("ld", 16'h2205, 1'b0, e, 1'b0, z);
        e.dmem_r_addr_sel = 2'd3; e.rf_rq_rd = 1;
        add_vec("ldr", 16'h6245, 1'b0, e, 1'b0, z);
        e = '0; e.rf_w_wr = 1; e.rf_w_data_sel = 2'd2; e.nzp_ld = 1;
        add_vec("lea", 16'hE205, 1'b0, e, 1'b0, z);
        // ST / STR
        e = '0; e.dmem_wr = 1; e.rf_rp_rd = 1; e.dmem_w_addr_sel = 2'd0;
        add_vec("st", 16'h3205, 1'b0, e, 1'b0, z);
        e.dmem_w_addr_sel = 2'd2; e.rf_rq_rd = 1;
        add_vec("str", 16'h7245, 1'b0, e, 1'b0, z);
        // LDI / STI
        e = '0; e.dmem_rd = 1; e.dmem_r_addr_sel = 2'd1; e.temp_ld = 1;
        e2 = '0; e2.dmem_rd = 1; e2.dmem_r_addr_sel = 2'd2; e2.rf_w_wr = 1;
        e2.rf_w_data_sel = 2'd1; e2.nzp_ld = 1;
        add_vec("ldi", 16'hA005, 1'b0, e, 1'b1, e2);
        e2 = '0; e2.dmem_wr = 1; e2.dmem_w_addr_sel = 2'd1; e2.rf_rp_rd = 1;
        add_vec("sti", 16'hB005, 1'b1, e, 1'b1, e2);
        // Unsupported opcodes
        add_vec("op_1000", 16'h8000, 1'b1, z, 1'b0, z);
        add_vec("op_1101", 16'hDFFF, 1'b1, z, 1'b0, z);

        // Reset, released after one edge: INIT then FETCH
        rst = 1'b1; ir = 16'h0000; nzp_match = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        push_exp(exp_init());
        check_cycle("reset_init");

        // Table: each vector enters from FETCH
        foreach (vecs[k]) begin
            ir = vecs[k].ir;
            nzp_match = vecs[k].nzp;
            push_exp(exp_fetch());
            check_cycle({vecs[k].name, "_fetch"});
            push_exp(vecs[k].exp_exec);
            check_cycle({vecs[k].name, "_exec"});
            if (vecs[k].has2) begin
                push_exp(vecs[k].exp_exec2);
                check_cycle({vecs[k].name, "_exec2"});
            end
        end

        // Random ADD/AND immediates: alu_in_a_sel must follow ir[5]
        for (int r = 0; r < 6; r++) begin
            logic [15:0] ri;
            ri = 16'($urandom_range(0, 16'hFFFF));
            ri[15:12] = (r % 2 == 0) ? 4'b0001 : 4'b0101;
            ir = ri;
            nzp_match = 1'($urandom_range(0, 1));
            push_exp(exp_fetch());
            check_cycle("rnd_fetch");
            e = '0; e.rf_w_wr = 1; e.rf_rq_rd = 1; e.rf_rp_rd = 1; e.rf_rp_addr_sel = 1;
            e.alu_sel = (r % 2 == 0) ? 2'd0 : 2'd1; e.alu_in_a_sel = ri[5]; e.nzp_ld = 1;
            push_exp(e);
            check_cycle("rnd_exec");
        end

        // LDI with reset asserted during EXEC2: next cycle is INIT, no write
        ir = 16'hA005;
        push_exp(exp_fetch());
        check_cycle("ldi_rst_fetch");
        e = '0; e.dmem_rd = 1; e.dmem_r_addr_sel = 2'd1; e.temp_ld = 1;
        push_exp(e);
        check_cycle("ldi_rst_exec");
        rst = 1'b1;
        e2 = '0; e2.dmem_rd = 1; e2.dmem_r_addr_sel = 2'd2; e2.rf_w_wr = 1;
        e2.rf_w_data_sel = 2'd1; e2.nzp_ld = 1;
        push_exp(e2);
        check_cycle("ldi_rst_exec2");
        rst = 1'b0;
        push_exp(exp_init());
        check_cycle("ldi_rst_init");

        // TRAP: HALT holds with any ir until reset
        ir = 16'hF025;
        push_exp(exp_fetch());
        check_cycle("trap_fetch");
        push_exp(z);
        check_cycle("trap_exec");
        for (int h = 0; h < 22; h++) begin
            ir = 16'($urandom_range(0, 16'hFFFF));
            nzp_match = 1'($urandom_range(0, 1));
            push_exp(exp_halt());
            check_cycle("halt_hold");
        end
        rst = 1'b1;
        push_exp(exp_halt());
        check_cycle("halt_rst");
        rst = 1'b0;
        push_exp(exp_init());
        check_cycle("halt_init");
        push_exp(exp_fetch());
        check_cycle("halt_fetch");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/punc_control.md
Name: punc_control

Overview:
- Control FSM for the PUnC LC3 processor; sits directly upstream of the PUnC datapath and drives every datapath control input.
- Consumes the datapath's instruction register copy (ir) and branch-condition result (nzp_match).
- Sequences fetch / execute / second-execute for the LC3 subset: ADD, AND, NOT, BR, JMP/RET, JSR/JSRR, LD, LDI, LDR, LEA, ST, STI, STR, TRAP (halt).

Parameters:
- none (all encodings come from the shared defines package)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ir  in  16  current instruction from datapath
- nzp_match  in  1  BR condition satisfied (unconditional encodings also give 1)
- pc_ld, pc_clr, pc_inc  out  1 each  PC load / clear / +1
- pc_sel  out  2  0=PC+sext(ir[8:0]), 1=PC+sext(ir[10:0]), 2=Rq data
- ir_ld, ir_clr  out  1 each  IR load from dmem read port / clear
- dmem_rd, dmem_wr  out  1 each  memory read strobe / write enable
- dmem_r_addr_sel  out  2  0=PC, 1=PC+sext9, 2=temp, 3=Rq+sext(ir[5:0])
- dmem_w_addr_sel  out  2  0=PC+sext9, 1=temp, 2=Rq+sext6
- rf_w_data_sel  out  2  0=ALU, 1=dmem read data, 2=PC+sext9, 3=PC
- rf_w_addr_sel  out  1  0=ir[11:9], 1=R7
- rf_w_wr  out  1  register-file write enable
- rf_rp_addr_sel  out  1  0=ir[11:9], 1=ir[2:0]
- rf_rp_rd, rf_rq_rd  out  1 each  read strobes (Rq address fixed at ir[8:6])
- temp_ld  out  1  temp <= dmem read data
- nzp_ld, nzp_clr  out  1 each  condition-code load (from rf write data) / clear
- alu_sel  out  2  0=ADD, 1=AND, 2=NOT, 3=pass Rq
- alu_in_a_sel  out  1  second ALU operand: 0=Rp data, 1=sext(ir[4:0])
- halted  out  1  high in HALT state

Behaviour:
- States: INIT, FETCH, EXEC, EXEC2, HALT. Outputs purely combinational from state, ir, nzp_match; every output is 0 unless listed for the state.
- rst: state <= INIT next edge, regardless of current state (including mid-LDI/STI or HALT).
- INIT: pc_clr=ir_clr=nzp_clr=1; -> FETCH.
- FETCH: dmem_rd=1, dmem_r_addr_sel=0, ir_ld=1, pc_inc=1; -> EXEC. All PC-relative math in EXEC uses the incremented PC.
- EXEC, by ir[15:12]:
  - ADD 0001 / AND 0101: rf_w_wr, rf_w_addr_sel=0, rf_w_data_sel=0, alu_sel=0/1, rf_rq_rd, rf_rp_rd, rf_rp_addr_sel=1, alu_in_a_sel=ir[5], nzp_ld.
  - NOT 1001: as ADD with alu_sel=2, no rf_rp_rd.
  - BR 0000: pc_ld=nzp_match, pc_sel=0. ir[11:9]=000 is taken (nzp_match=1).
  - JMP 1100: rf_rq_rd, pc_ld, pc_sel=2.
  - JSR/JSRR 0100: rf_w_wr, rf_w_addr_sel=1, rf_w_data_sel=3, pc_ld, pc_sel = ir[11]?1:2, rf_rq_rd. JSRR R7 is correct because the read returns the pre-write value.
  - LD 0010: dmem_rd, r_addr_sel=1, rf_w_wr, rf_w_data_sel=1, nzp_ld.
  - LDR 0110: as LD, r_addr_sel=3, rf_rq_rd.
  - LEA 1110: rf_w_wr, rf_w_data_sel=2, nzp_ld.
  - ST 0011 / STR 0111: dmem_wr, rf_rp_rd, rp_addr_sel=0, w_addr_sel=0/2 (STR also rf_rq_rd).
  - LDI 1010 / STI 1011: dmem_rd, r_addr_sel=1, temp_ld; -> EXEC2.
  - TRAP 1111: -> HALT.
  - 1000, 1101 (unsupported): no effect.
- Next state from EXEC: -> FETCH, except the LDI/STI and TRAP transitions above.
- EXEC2:
  - LDI: dmem_rd, r_addr_sel=2, rf_w_wr, rf_w_data_sel=1, nzp_ld.
  - STI: dmem_wr, w_addr_sel=1, rf_rp_rd, rp_addr_sel=0.
  - -> FETCH.
- HALT: halted=1, all strobes 0; held until rst.
- Latency: 2 cycles per instruction, 3 for LDI/STI.
- Never asserts dmem_wr and rf_w_wr in the same cycle.
- pc_ld and pc_inc are never both high.

Decomposition:
- Shared defines package: opcode constants, state encodings, all select encodings above, BR_N/BR_Z/BR_P bit indices.
- Single module, no sub-module: next-state logic plus an output-decode case statement.

Test Plan:
- Reset then hold: rst=1 one cycle -> INIT shows pc_clr=ir_clr=nzp_clr=1; next cycle FETCH shows ir_ld=1, pc_inc=1, dmem_r_addr_sel=0.
- ir=0x1262 (ADD R1,R1,#2) in EXEC -> rf_w_wr=1, alu_sel=0, alu_in_a_sel=1, nzp_ld=1; following cycle is FETCH.
- ir=0x0402 (BRz), nzp_match=0 -> pc_ld=0; nzp_match=1 -> pc_ld=1, pc_sel=0.
- ir=0xA005 (LDI) -> EXEC: temp_ld=1, r_addr_sel=1; EXEC2: r_addr_sel=2, rf_w_wr=1, rf_w_data_sel=1; then FETCH. Repeat with rst in EXEC2 -> INIT next cycle, no write in the INIT cycle.
- ir=0x4FFF (JSR -1) -> rf_w_addr_sel=1, rf_w_data_sel=3, pc_ld=1, pc_sel=1.
- ir=0xF025 (TRAP HALT) -> HALT, halted=1, all strobes 0 for 20+ cycles; rst returns to INIT.
